// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU.
//
// Accepts an opcode and two operands through a valid/ready input and returns
// a registered result plus carry/zero/negative/overflow flags through a
// valid/ready output. Arithmetic and logic ops complete on the acceptance
// edge. Multi-bit shifts run one bit per cycle.
//
// Optional feature macro: ALU_SEQ_ROTATE_EN adds ROR (opcode 000111).
// Without it, 000111 is an unknown code and executes ADD.
//
// Ports:
//   i_clock      in   system clock, rising edge
//   i_reset_n    in   asynchronous active-low reset
//   i_valid      in   request valid
//   o_ready      out  block can accept a request (IDLE only)
//   i_opcode     in   operation code
//   i_dato_a     in   operand A / shift source
//   i_dato_b     in   operand B; [SHW-1:0] is the shift amount
//   o_valid      out  result valid (DONE only)
//   i_ready      in   consumer accepts result
//   o_result     out  result
//   o_carry, o_zero, o_negative, o_overflow  out  flags
module alu_seq #(
  parameter int BUS_SIZE    = 8,
  parameter int OPCODE_SIZE = 6
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [OPCODE_SIZE-1:0] i_opcode,
  input  logic [BUS_SIZE-1:0]    i_dato_a,
  input  logic [BUS_SIZE-1:0]    i_dato_b,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [BUS_SIZE-1:0]    o_result,
  output logic                   o_carry,
  output logic                   o_zero,
  output logic                   o_negative,
  output logic                   o_overflow
);

  localparam int SHW = $clog2(BUS_SIZE);
  localparam int MSB = BUS_SIZE - 1;

  localparam logic [OPCODE_SIZE-1:0] OPC_ADD = OPCODE_SIZE'(6'b100000);
  localparam logic [OPCODE_SIZE-1:0] OPC_SUB = OPCODE_SIZE'(6'b100010);
  localparam logic [OPCODE_SIZE-1:0] OPC_AND = OPCODE_SIZE'(6'b100100);
  localparam logic [OPCODE_SIZE-1:0] OPC_OR  = OPCODE_SIZE'(6'b100101);
  localparam logic [OPCODE_SIZE-1:0] OPC_XOR = OPCODE_SIZE'(6'b100110);
  localparam logic [OPCODE_SIZE-1:0] OPC_NOR = OPCODE_SIZE'(6'b100111);
  localparam logic [OPCODE_SIZE-1:0] OPC_SRL = OPCODE_SIZE'(6'b000010);
  localparam logic [OPCODE_SIZE-1:0] OPC_SRA = OPCODE_SIZE'(6'b000011);
  localparam logic [OPCODE_SIZE-1:0] OPC_SLL = OPCODE_SIZE'(6'b000000);
`ifdef ALU_SEQ_ROTATE_EN
  localparam logic [OPCODE_SIZE-1:0] OPC_ROR = OPCODE_SIZE'(6'b000111);
`endif

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_NOR,
    OP_SRL,
    OP_SRA,
    OP_SLL,
    OP_ROR
  } op_t;

  state_t              state;
  state_t              state_next;
  op_t                 req_op;
  op_t                 cur_op;
  logic                req_is_shift;
  logic                req_iter;
  logic [SHW-1:0]      req_amt;
  logic                accept;
  logic [BUS_SIZE-1:0] work;
  logic [SHW-1:0]      cnt;
  logic                cnt_last;
  logic [BUS_SIZE-1:0] step_val;
  logic                step_out;
  logic [BUS_SIZE:0]   sum;
  logic [BUS_SIZE:0]   diff;
  logic [BUS_SIZE-1:0] imm_res;
  logic                imm_carry;
  logic                imm_ovf;

  // Opcode decode; anything unrecognised falls back to ADD.
  always_comb begin
    req_op = OP_ADD;
    case (i_opcode)
      OPC_ADD: req_op = OP_ADD;
      OPC_SUB: req_op = OP_SUB;
      OPC_AND: req_op = OP_AND;
      OPC_OR:  req_op = OP_OR;
      OPC_XOR: req_op = OP_XOR;
      OPC_NOR: req_op = OP_NOR;
      OPC_SRL: req_op = OP_SRL;
      OPC_SRA: req_op = OP_SRA;
      OPC_SLL: req_op = OP_SLL;
`ifdef ALU_SEQ_ROTATE_EN
      OPC_ROR: req_op = OP_ROR;
`endif
      default: req_op = OP_ADD;
    endcase
  end

  assign req_amt      = i_dato_b[SHW-1:0];
  assign req_is_shift = (req_op == OP_SRL) || (req_op == OP_SRA) ||
                        (req_op == OP_SLL) || (req_op == OP_ROR);
  // Only shifts with a non-zero amount need the iterative path.
  assign req_iter     = req_is_shift && (req_amt != '0);

  // Arithmetic at BUS_SIZE+1 bits: top bit is carry-out / borrow.
  assign sum  = {1'b0, i_dato_a} + {1'b0, i_dato_b};
  assign diff = {1'b0, i_dato_a} - {1'b0, i_dato_b};

  // Single-cycle result path (non-shift ops, and shifts by zero).
  always_comb begin
    imm_res   = '0;
    imm_carry = 1'b0;
    imm_ovf   = 1'b0;
    case (req_op)
      OP_SUB: begin
        imm_res   = diff[MSB:0];
        imm_carry = diff[BUS_SIZE];
        imm_ovf   = (i_dato_a[MSB] ^ i_dato_b[MSB]) & (diff[MSB] ^ i_dato_a[MSB]);
      end
      OP_AND: imm_res = i_dato_a & i_dato_b;
      OP_OR:  imm_res = i_dato_a | i_dato_b;
      OP_XOR: imm_res = i_dato_a ^ i_dato_b;
      OP_NOR: imm_res = ~(i_dato_a | i_dato_b);
      OP_SRL, OP_SRA, OP_SLL, OP_ROR: imm_res = i_dato_a;
      default: begin
        imm_res   = sum[MSB:0];
        imm_carry = sum[BUS_SIZE];
        imm_ovf   = ~(i_dato_a[MSB] ^ i_dato_b[MSB]) & (sum[MSB] ^ i_dato_a[MSB]);
      end
    endcase
  end

  // One-bit shift step of the working register.
  always_comb begin
    step_val = work;
    step_out = 1'b0;
    case (cur_op)
      OP_SRA: begin
        step_val = {work[MSB], work[MSB:1]};
        step_out = work[0];
      end
      OP_SLL: begin
        step_val = {work[MSB-1:0], 1'b0};
        step_out = work[MSB];
      end
`ifdef ALU_SEQ_ROTATE_EN
      OP_ROR: begin
        step_val = {work[0], work[MSB:1]};
        step_out = work[0];
      end
`endif
      default: begin
        step_val = {1'b0, work[MSB:1]};
        step_out = work[0];
      end
    endcase
  end

  assign cnt_last = (cnt == SHW'(1));

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          accept     = 1'b1;
          state_next = req_iter ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (cnt_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are only written on DONE entry; the working register carries
  // the in-flight shift so o_result stays at the previous value meanwhile.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cur_op     <= OP_ADD;
      work       <= '0;
      cnt        <= '0;
      o_result   <= '0;
      o_carry    <= 1'b0;
      o_zero     <= 1'b0;
      o_negative <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (accept) begin
        cur_op <= req_op;
        work   <= i_dato_a;
        cnt    <= req_amt;
        if (!req_iter) begin
          o_result   <= imm_res;
          o_carry    <= imm_carry;
          o_zero     <= (imm_res == '0);
          o_negative <= imm_res[MSB];
          o_overflow <= imm_ovf;
        end
      end
      if (state == SHIFT) begin
        work <= step_val;
        cnt  <= cnt - SHW'(1);
        if (cnt_last) begin
          o_result   <= step_val;
          o_carry    <= step_out;
          o_zero     <= (step_val == '0);
          o_negative <= step_val[MSB];
          o_overflow <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's button-loaded ALU. It accepts an opcode and two operands through a valid/ready input, runs multi-bit shifts one bit per cycle, and returns a registered result with carry/zero/negative/overflow flags through a valid/ready output. It sits between the operand/opcode source (switch/button front-end or a bus master) and the result consumer (display or register file).

## Interface
- `BUS_SIZE`, 8, operand/result width (≥ 2, power of two).
- `OPCODE_SIZE`, 6, opcode width.
- `SHW` (localparam), `$clog2(BUS_SIZE)`, shift-amount width.

- `i_clock`  in  1  system clock, rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  request valid.
- `o_ready`  out  1  block can accept a request.
- `i_opcode`  in  OPCODE_SIZE  operation.
- `i_dato_a`  in  BUS_SIZE  operand A / shift source.
- `i_dato_b`  in  BUS_SIZE  operand B; `[SHW-1:0]` is the shift amount.
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  consumer accepts result.
- `o_result`  out  BUS_SIZE  result.
- `o_carry`, `o_zero`, `o_negative`, `o_overflow`  out  1 each  flags.

## Operation
- Opcodes:
  - ADD 100000
  - SUB 100010
  - AND 100100
  - OR 100101
  - XOR 100110
  - NOR 100111
  - SRL 000010
  - SRA 000011
  - SLL 000000
  - Any other code executes ADD.
- FSM states:
  - IDLE: `o_ready`=1; `o_ready` is 1 only in this state.
  - SHIFT: iterative shift in progress.
  - DONE: `o_valid`=1.
- Acceptance occurs on an edge with `i_valid && o_ready`. Opcode and operands are captured on that edge; later input changes have no effect.
- Non-shift op, or shift with amount 0: IDLE→DONE on the acceptance edge, with result and flags registered.
- Shift with amount n>0: IDLE→SHIFT, counter=n. Each edge shifts the working register by one bit and decrements the counter. The edge that performs the n-th shift moves to DONE.
- DONE: result and flags are held stable until `i_ready`=1. DONE→IDLE on that edge.
- `i_valid` is ignored outside IDLE.
- Arithmetic is computed at BUS_SIZE+1 bits.
- Carry:
  - ADD: carry-out.
  - SUB: borrow, i.e. 1 when A<B unsigned.
  - Shifts/rotate: last bit shifted out (0 when amount is 0).
  - Logic ops: 0.
- Overflow: signed overflow for ADD/SUB; 0 for all other ops.
- Zero: result == 0. Negative: result[BUS_SIZE-1].
- SRA replicates the MSB. SRL and SLL fill with 0.

## Timing
- Reset (asynchronous assert, synchronous release) goes to IDLE.
- Reset values: `o_ready`=1, `o_valid`=0, `o_result`=0, all flags 0.
- Reset mid-SHIFT or mid-DONE aborts immediately and discards the result.
- Latency is measured from the acceptance edge (edge 0). `o_valid` is high after edge 0 for non-shift ops and after edge n for shifts of n.
- Minimum occupancy is 2 cycles per operation: there is no accept in the same cycle as the DONE handshake.
- `o_result` and flags change only on DONE entry.
- `o_ready` is derived combinationally from state: low from the cycle after acceptance until the cycle after the DONE handshake.

## Configuration
- `ALU_SEQ_ROTATE_EN`
  - Defined: adds ROR, opcode 000111. It rotates A right by the shift amount, one bit per cycle, with the same latency as the other shifts. Carry = last bit rotated out.
  - Undefined: 000111 is an unknown code and executes ADD with 1-cycle latency.

## Test plan
All scenarios use BUS_SIZE=8.
- ADD A=0xFF B=0x01 -> `o_valid` after edge 0; result 0x00, carry=1, zero=1, overflow=0, negative=0.
- SUB A=0x80 B=0x01 -> 0x7F, overflow=1, carry=0. SUB A=0x01 B=0x02 -> 0xFF, carry=1, negative=1, overflow=0.
- SRA A=0x90 B=0x03 -> `o_ready` low during SHIFT, `o_valid` after edge 3; result 0xF2, carry=0, negative=1. SLL A=0x81 B=0x01 -> 0x02, carry=1.
- Backpressure: hold `i_ready`=0 for 5 cycles in DONE and pulse `i_valid` with a new op -> outputs stay stable and the new op is ignored. Then `i_ready`=1 -> IDLE next cycle with `o_ready`=1.
- Reset mid-shift: SRL B=0x07, drive `i_reset_n` low after the 3rd shift edge -> `o_valid`=0, `o_result`=0, `o_ready`=1 immediately. After release, ADD 0x02+0x03 -> 0x05.
- Macro: ROR A=0x81 B=0x01 -> with `ALU_SEQ_ROTATE_EN` defined: 0xC0, carry=1, after edge 1. Without it: 0x82, carry=0, after edge 0.
